alu_cmd_sequencer: RTL and testbench

Command front-end that sits directly upstream of the 32-bit ALU. It accepts ALU commands over a valid/ready handshake and drives the ALU's opcode and operand inputs, holding them stable for the ALU's two-register pipeline. It captures the ALU result at a fixed cycle and returns it over a second valid/ready handshake. An accumulator option feeds the previous result back as operand A, so chained operations need no external storage.

---
 rtl/alu_cmd_sequencer.sv | 89 ++++++++
 tb/tb_alu_cmd_sequencer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// Command front-end for the two-stage ALU: issues one command at a time, holds operands
// stable, captures Y after LAT edges and returns it over a valid/ready handshake.
module alu_cmd_sequencer #(
  parameter int WIDTH = 32,
  parameter int LAT   = 2
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [4:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic             cmd_use_acc,
  output logic [4:0]       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_y,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_zero,
  output logic             busy,
  output logic [15:0]      op_count
);

  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, CAPT, RESP} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   wait_cnt;
  logic [WIDTH-1:0] acc;
  logic            accept;

  // Handshake outputs decode registered state only, so no input reaches them combinationally.
  assign cmd_ready = (state == IDLE);
  assign res_valid = (state == RESP);
  assign busy      = (state != IDLE);
  assign accept    = cmd_valid && cmd_ready;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (cmd_valid)        state_nxt = EXEC;
      EXEC: if (wait_cnt == '0)   state_nxt = CAPT;
      CAPT:                       state_nxt = RESP;
      RESP: if (res_ready)        state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  // ALU inputs change only on accept so Op[1:0] is still valid at the ALU's second edge.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      alu_op   <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      wait_cnt <= '0;
      res_data <= '0;
      res_zero <= 1'b1;
      acc      <= '0;
      op_count <= '0;
    end else begin
      if (accept) begin
        alu_op   <= cmd_op;
        alu_b    <= cmd_b;
        alu_a    <= cmd_use_acc ? acc : cmd_a;
        wait_cnt <= CW'(LAT - 1);
      end else if (state == EXEC && wait_cnt != '0) begin
        wait_cnt <= wait_cnt - 1'b1;
      end
      if (state == CAPT) begin
        res_data <= alu_y;
        acc      <= alu_y;
        res_zero <= (alu_y == '0);
      end
      if (state == RESP && res_ready) begin
        op_count <= op_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a behavioural two-register ALU supplying alu_y.
module tb_alu_cmd_sequencer;

  logic        Clock = 1'b0;
  logic        Reset_n;
  logic        cmd_valid, cmd_ready, cmd_use_acc;
  logic [4:0]  cmd_op, alu_op;
  logic [31:0] cmd_a, cmd_b, alu_a, alu_b, alu_y, res_data;
  logic        res_valid, res_ready, res_zero, busy;
  logic [15:0] op_count;
  logic [31:0] y_temp;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 Clock = ~Clock;

  alu_cmd_sequencer #(.WIDTH(32), .LAT(2)) dut (
    .Clock(Clock), .Reset_n(Reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_zero(res_zero), .busy(busy), .op_count(op_count)
  );

  // ALU model: function stage into y_temp, then post-shift stage into Y; never reset.
  function automatic logic [31:0] alu_fn(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    case (f)
      3'd0: alu_fn = a;
      3'd1: alu_fn = a + b;
      3'd2: alu_fn = a - b;
      3'd3: alu_fn = a & b;
      3'd4: alu_fn = a | b;
      3'd5: alu_fn = a ^ b;
      3'd6: alu_fn = b;
      default: alu_fn = ~a;
    endcase
  endfunction

  function automatic logic [31:0] alu_sh(input logic [1:0] s, input logic [31:0] v);
    case (s)
      2'd0: alu_sh = v;
      2'd1: alu_sh = v << 1;
      2'd2: alu_sh = v >> 1;
      default: alu_sh = 32'd0;
    endcase
  endfunction

  initial begin
    y_temp = 32'd0;
    alu_y  = 32'd0;
  end

  always @(posedge Clock) begin
    y_temp <= alu_fn(alu_op[4:2], alu_a, alu_b);
    alu_y  <= alu_sh(alu_op[1:0], y_temp);
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Drives one full transaction; returns observed latency (-1 on timeout) and the result.
  task automatic run_cmd(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic ua, output int lat, output logic [31:0] a_seen,
                         output logic [31:0] data, output logic zero);
    int n;
    n = 0;
    while (!cmd_ready && n < 20) begin tick(); n++; end
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_use_acc = ua; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    a_seen = alu_a;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (res_valid) begin lat = i; break; end
    end
    data = res_data;
    zero = res_zero;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; cmd_use_acc = 1'b0; res_ready = 1'b0;
    tick(); tick();
    Reset_n = 1'b1;
    tick();
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready got %b want 1", cmd_ready); end
    n_checks++; if ({res_valid, busy, res_zero} !== 3'b001) begin n_fail++; $display("FAIL reset_flags got %b want 001", {res_valid, busy, res_zero}); end
    n_checks++; if ({alu_op, alu_a, alu_b, res_data, op_count} !== '0) begin n_fail++; $display("FAIL reset_regs got %h/%h/%h/%h/%h want 0", alu_op, alu_a, alu_b, res_data, op_count); end
    // Park a command in RESP, then reset asynchronously between edges.
    cmd_op = 5'b00100; cmd_a = 32'd1; cmd_b = 32'd1; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick(); tick(); tick();
    n_checks++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL reset_pre_resp got %b want 1", res_valid); end
    #3 Reset_n = 1'b0;
    #1;
    n_checks++; if ({res_valid, busy, res_zero, cmd_ready} !== 4'b0011) begin n_fail++; $display("FAIL reset_async_flags got %b want 0011", {res_valid, busy, res_zero, cmd_ready}); end
    n_checks++; if ({alu_op, alu_a, alu_b, res_data} !== '0) begin n_fail++; $display("FAIL reset_async_regs got %h/%h/%h/%h want 0", alu_op, alu_a, alu_b, res_data); end
    tick();
    Reset_n = 1'b1;
    tick();
    n_checks++; if ({cmd_ready, res_valid, op_count} !== {2'b10, 16'd0}) begin n_fail++; $display("FAIL reset_release got %b/%b/%h want 1/0/0", cmd_ready, res_valid, op_count); end
  endtask

  task automatic test_single_add();
    int lat;
    cmd_op = 5'b00100; cmd_a = 32'd5; cmd_b = 32'd7; cmd_use_acc = 1'b0; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    n_checks++; if ({alu_op, alu_a, alu_b} !== {5'b00100, 32'd5, 32'd7}) begin n_fail++; $display("FAIL add_issue got %b/%0d/%0d want 00100/5/7", alu_op, alu_a, alu_b); end
    n_checks++; if ({cmd_ready, busy} !== 2'b01) begin n_fail++; $display("FAIL add_busy got %b want 01", {cmd_ready, busy}); end
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (res_valid) begin lat = i; break; end
    end
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL add_latency got %0d want 3", lat); end
    n_checks++; if ({res_data, res_zero} !== {32'd12, 1'b0}) begin n_fail++; $display("FAIL add_result got %0d/%b want 12/0", res_data, res_zero); end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    n_checks++; if ({op_count, res_valid, cmd_ready} !== {16'd1, 2'b01}) begin n_fail++; $display("FAIL add_done got %0d/%b/%b want 1/0/1", op_count, res_valid, cmd_ready); end
  endtask

  task automatic test_acc_chain();
    int lat; logic [31:0] a_seen, d; logic z;
    run_cmd(5'b00100, 32'd10, 32'd3, 1'b0, lat, a_seen, d, z);
    n_checks++; if (d !== 32'd13) begin n_fail++; $display("FAIL chain1 got %0d want 13", d); end
    run_cmd(5'b00101, 32'hDEAD, 32'd2, 1'b1, lat, a_seen, d, z);
    n_checks++; if (a_seen !== 32'd13) begin n_fail++; $display("FAIL chain2_a got %0d want 13", a_seen); end
    n_checks++; if ({d, z} !== {32'd30, 1'b0}) begin n_fail++; $display("FAIL chain2 got %0d/%b want 30/0", d, z); end
    run_cmd(5'b11011, 32'd0, 32'd77, 1'b1, lat, a_seen, d, z);
    n_checks++; if ({a_seen, d, z, lat} !== {32'd30, 32'd0, 1'b1, 32'd3}) begin n_fail++; $display("FAIL chain3 got a=%0d d=%0d z=%b lat=%0d want 30/0/1/3", a_seen, d, z, lat); end
  endtask

  task automatic test_back_pressure();
    int n; int bad;
    cmd_op = 5'b00100; cmd_a = 32'd100; cmd_b = 32'd1; cmd_use_acc = 1'b0; cmd_valid = 1'b1;
    tick();
    cmd_a = 32'd1; cmd_b = 32'd1;
    n = 0;
    while (!res_valid && n < 20) begin tick(); n++; end
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      if (res_valid !== 1'b1 || cmd_ready !== 1'b0 || res_data !== 32'd101 || res_zero !== 1'b0) bad++;
      tick();
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL bp_hold got %0d bad cycles want 0 (data=%0d)", bad, res_data); end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    n_checks++; if ({cmd_ready, busy, alu_a} !== {2'b10, 32'd100}) begin n_fail++; $display("FAIL bp_release got %b/%b/%0d want 1/0/100", cmd_ready, busy, alu_a); end
    tick();
    cmd_valid = 1'b0;
    n_checks++; if ({busy, alu_a} !== {1'b1, 32'd1}) begin n_fail++; $display("FAIL bp_next_accept got %b/%0d want 1/1", busy, alu_a); end
    n = 0;
    while (!res_valid && n < 20) begin tick(); n++; end
    n_checks++; if (res_data !== 32'd2) begin n_fail++; $display("FAIL bp_next_result got %0d want 2", res_data); end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    int lat; int seen; logic [31:0] a_seen, d; logic z;
    cmd_op = 5'b00100; cmd_a = 32'd7; cmd_b = 32'd8; cmd_use_acc = 1'b0; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    #2 Reset_n = 1'b0;
    #3 Reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (res_valid) seen++;
    end
    n_checks++; if ({seen, op_count, busy} !== {32'd0, 16'd0, 1'b0}) begin n_fail++; $display("FAIL midreset_discard got seen=%0d cnt=%0d busy=%b want 0/0/0", seen, op_count, busy); end
    run_cmd(5'b00100, 32'd999, 32'd4, 1'b1, lat, a_seen, d, z);
    n_checks++; if ({a_seen, d, op_count} !== {32'd0, 32'd4, 16'd1}) begin n_fail++; $display("FAIL midreset_next got a=%0d d=%0d cnt=%0d want 0/4/1", a_seen, d, op_count); end
  endtask

  task automatic test_wrap_and_sub();
    int lat; logic [31:0] a_seen, d; logic z;
    force dut.op_count = 16'hFFFF;
    #1;
    release dut.op_count;
    #1;
    n_checks++; if (op_count !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_preload got %h want ffff", op_count); end
    run_cmd(5'b01000, 32'd0, 32'd1, 1'b0, lat, a_seen, d, z);
    n_checks++; if (op_count !== 16'h0000) begin n_fail++; $display("FAIL wrap got %h want 0000", op_count); end
    n_checks++; if ({d, z} !== {32'hFFFFFFFF, 1'b0}) begin n_fail++; $display("FAIL sub_underflow got %h/%b want ffffffff/0", d, z); end
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_acc_chain();
    test_back_pressure();
    test_reset_mid_op();
    test_wrap_and_sub();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
